// File: rtl/cpu_pkg.sv
// Shared CPU definitions: mul/div op encodings, mul/div FSM states and
// the funct codes the control unit decodes for the HI/LO moves.
package cpu_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } muldiv_state_t;

  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MTHI = 6'h11;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MTLO = 6'h13;

endpackage

// File: rtl/cond_negate.sv
// Combinational two's-complement negate, applied only when neg is set.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = neg ? (~value + WIDTH'(1)) : value;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add / restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction of magnitude results, HI/LO written
// DONE  | done pulse; a new start may be accepted here
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t        state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_next, prod_fix;
  logic [WIDTH-1:0]     opnd, mag_a, mag_b, quo_fix, rem_fix, diff;
  logic [WIDTH:0]       sum, rem_sh;
  logic                 is_div, res_sign, rem_sign, dbz;
  logic                 a_neg, b_neg, b_zero, op_div;

  assign a_neg  = op[0] & a[WIDTH-1];
  assign b_neg  = op[0] & b[WIDTH-1];
  assign b_zero = (b == '0);
  assign op_div = (op == OP_DIVU) || (op == OP_DIV);

  cond_negate #(.WIDTH(WIDTH))   u_mag_a (.value(a), .neg(a_neg), .result(mag_a));
  cond_negate #(.WIDTH(WIDTH))   u_mag_b (.value(b), .neg(b_neg), .result(mag_b));
  cond_negate #(.WIDTH(2*WIDTH)) u_prod  (.value(acc), .neg(res_sign), .result(prod_fix));
  cond_negate #(.WIDTH(WIDTH))   u_quo   (.value(acc[WIDTH-1:0]), .neg(res_sign), .result(quo_fix));
  cond_negate #(.WIDTH(WIDTH))   u_rem   (.value(acc[2*WIDTH-1:WIDTH]), .neg(rem_sign), .result(rem_fix));

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      if (rem_sh >= {1'b0, opnd}) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else                        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      res_sign    <= 1'b0;
      rem_sign    <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              is_div <= op_div;
              opnd   <= op_div ? mag_b : mag_a;
              acc    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
              // a zero divisor must leave the all-ones quotient un-negated
              res_sign <= (a_neg ^ b_neg) & ~(op_div & b_zero);
              rem_sign <= op_div & a_neg;
              dbz      <= op_div & b_zero;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              state <= IDLE;
            end
          end
          RUN: begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= dbz;
            state       <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the pipelined CPU's EX stage, executing MIPS MULT, MULTU, DIV and DIVU into dedicated HI/LO registers. It is parametrised in data width. It raises `busy` so the hazard logic can stall the IF/ID/EX registers while an operation is in flight. It also supports MTHI/MTLO writes and a pipeline flush that aborts an in-flight operation.

## Interface
Parameters:
- `WIDTH`, default 32: operand width and width of each of HI and LO.
- `CNT_W`, default $clog2(WIDTH+1): width of the iteration counter.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous reset, active-high.
- `start` in 1: request a new operation; sampled only when not busy.
- `op` in 2: operation select. 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `a` in WIDTH: multiplicand or dividend (rs).
- `b` in WIDTH: multiplier or divisor (rt).
- `flush` in 1: abort the in-flight operation.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: operation in progress; the stall request.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `div_by_zero` out 1: valid with `done`; set when a DIV/DIVU had b == 0.
- `hi` out WIDTH: HI register (product high half / remainder).
- `lo` out WIDTH: LO register (product low half / quotient).

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, with `start`=1 and `flush`=0:
  - Latch the operand magnitudes: absolute values when op[0]=1, raw values otherwise.
  - Latch the result sign and the remainder sign.
  - Clear the counter and go to RUN.
- RUN: one iteration per cycle for exactly WIDTH cycles, then go to FIX.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX, one cycle:
  - Conditionally negate the results. Product takes the result sign. Quotient takes sign(a) xor sign(b). Remainder takes sign(a).
  - Write HI/LO, then go to DONE.
- DONE, one cycle: `done`=1, then go to IDLE, or to RUN if a new `start` arrives.
- Signed division truncates toward zero.
- Most-negative ÷ −1 gives LO = 1 followed by zeros (the most-negative value) and HI = 0. This falls out of the magnitude algorithm with no special case.
- Divide by zero: same latency. HI = a, LO = all ones, `div_by_zero`=1.
- `start` while `busy`=1 is ignored; no queueing.
- `flush`=1 in any state: return to IDLE on the next edge.
  - HI/LO are left unchanged and no `done` is produced.
  - `flush` overrides a simultaneous `start`.
- MTHI/MTLO:
  - `hi_we`/`lo_we` take effect at the edge only when `busy`=0; they are ignored while busy.
  - If one coincides with an accepted `start`, the write lands first and the operation result later overwrites it.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0; state IDLE, counter 0.
- Reset mid-operation behaves as reset: the operation is discarded and everything returns to the values above.
- `start` sampled at edge E0 ⇒ `busy`=1 from E0 through edge E0+WIDTH+1, i.e. WIDTH+1 cycles.
- `done`=1 in the single cycle after edge E0+WIDTH+1; `busy`=0 in that cycle.
- Total latency: `done` in the cycle WIDTH+2 cycles after the `start` cycle. For WIDTH=32 that is 34.
- Back-to-back: `start` in the DONE cycle is accepted, giving a throughput of one operation per WIDTH+2 cycles.
- `hi`/`lo` are registered outputs and change only at the FIX edge, on an MTHI/MTLO write, or at reset.
- `div_by_zero` is low outside the DONE cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - op encodings `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`;
  - the `muldiv_state_t` enum (IDLE, RUN, FIX, DONE);
  - the control-unit decode constants for MFHI, MFLO, MTHI and MTLO.
- One sub-module, `cond_negate`: combinational two's-complement negate when `neg`=1, parametrised by WIDTH. It is instantiated for the operand magnitudes and for the FIX-stage results.
- FSM, counter, accumulator and HI/LO registers live in `muldiv_unit` itself.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → `done` at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `busy` high for exactly 33 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → hi=0x00001234, lo=0xFFFFFFFF, `div_by_zero`=1 only in the `done` cycle.
- MTLO 0xAAAA when idle, then a MULT followed by `flush` at cycle 10 → no `done`; lo stays 0xAAAA, hi unchanged. MTHI asserted while busy is ignored.
- Second `start` during RUN is ignored. `start` in the DONE cycle is accepted, and its `done` arrives 34 cycles later. `reset` mid-RUN → all outputs 0 on the next cycle.
